// File: rtl/sram_port_arbiter_if.sv
// Memory-side port of sram_port_arbiter: address phase request and data phase response.
interface sram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [3:0]    bus_wen;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_wen, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_wen, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (I) and MEM-stage data (D) requests.
// Define ARB_FAIR_EN to let a waiting fetch win after MAX_D_RUN consecutive D grants.
module sram_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_ok,
    input  logic          data_req,
    input  logic [3:0]    data_wen,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_ok,
    input  logic          flush,
    sram_port_arbiter_if.master mem
);

    typedef enum logic [2:0] {
        IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT
    } state_e;

    state_e     state_q;
    logic       drop_q;
    logic       i_go;
    logic       pick_i;
    logic [1:0] d_size;

    assign i_go = inst_req & ~flush;

`ifdef ARB_FAIR_EN
    localparam int CW = $clog2(MAX_D_RUN + 1);
    logic [CW-1:0] run_cnt_q;

    assign pick_i = i_go & (run_cnt_q == CW'(MAX_D_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (pick_i || (!data_req && i_go))
                run_cnt_q <= '0;
            else if (data_req && !inst_req)
                run_cnt_q <= '0;
            else if (data_req && run_cnt_q != CW'(MAX_D_RUN))
                run_cnt_q <= run_cnt_q + 1'b1;
        end
    end
`else
    logic unused_max_d_run;
    assign unused_max_d_run = |MAX_D_RUN;
    assign pick_i = 1'b0;
`endif

    always_comb begin
        unique case (data_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: d_size = 2'd0;
            4'b0011, 4'b1100:                   d_size = 2'd1;
            default:                            d_size = 2'd2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_i)        state_q <= I_ADDR;
                    else if (data_req) state_q <= D_ADDR;
                    else if (i_go)     state_q <= I_ADDR;
                end
                D_ADDR: if (mem.bus_addr_ok) state_q <= D_WAIT;
                D_WAIT: if (mem.bus_data_ok) state_q <= IDLE;
                // A flushed fetch never reaches the bus
                I_ADDR: begin
                    if (flush)                state_q <= IDLE;
                    else if (mem.bus_addr_ok) state_q <= I_WAIT;
                end
                I_WAIT: begin
                    if (mem.bus_data_ok) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if (flush) begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem.bus_req   = 1'b0;
        mem.bus_wr    = 1'b0;
        mem.bus_size  = 2'd0;
        mem.bus_wen   = 4'b0;
        mem.bus_addr  = '0;
        mem.bus_wdata = '0;
        inst_ok       = 1'b0;
        inst_rdata    = '0;
        data_ok       = 1'b0;
        data_rdata    = '0;
        if (!rst) begin
            unique case (state_q)
                D_ADDR: begin
                    mem.bus_req   = 1'b1;
                    mem.bus_wr    = |data_wen;
                    mem.bus_size  = d_size;
                    mem.bus_wen   = data_wen;
                    mem.bus_addr  = data_addr;
                    mem.bus_wdata = data_wdata;
                end
                D_WAIT: if (mem.bus_data_ok) begin
                    data_ok    = 1'b1;
                    data_rdata = mem.bus_rdata;
                end
                I_ADDR: if (!flush) begin
                    mem.bus_req  = 1'b1;
                    mem.bus_size = 2'd2;
                    mem.bus_addr = inst_addr;
                end
                I_WAIT: if (mem.bus_data_ok && !drop_q && !flush) begin
                    inst_ok    = 1'b1;
                    inst_rdata = mem.bus_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed checks for sram_port_arbiter; the fairness sequence follows ARB_FAIR_EN.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        flush;

    int checks = 0;
    int failures = 0;

    sram_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    sram_port_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ok    (inst_ok),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ok    (data_ok),
        .flush      (flush),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, bus.bus_req, 0);
        chk({tag, "_iok"}, inst_ok, 0);
        chk({tag, "_dok"}, data_ok, 0);
        chk({tag, "_fld"}, {bus.bus_wr, bus.bus_size, bus.bus_wen,
                            bus.bus_addr}, 0);
    endtask

    logic exp_owner [6];
    int   grants;
    logic owner_q [$];

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_addr = 0; flush = 0;
        data_req = 1; data_wen = 4'hF; data_addr = 32'h10; data_wdata = 0;
        bus.bus_addr_ok = 1; bus.bus_data_ok = 1; bus.bus_rdata = 32'h1234;
        smp();
        chk_idle("rst");
        cyc();
        cyc();
        data_req = 0; bus.bus_addr_ok = 0; bus.bus_data_ok = 0;
        rst = 1'b0;

        // T1: plain fetch
        inst_req = 1; inst_addr = 32'h1000; bus.bus_addr_ok = 1;
        smp(); chk_idle("t1_idle");
        cyc();
        smp();
        chk("t1_req", bus.bus_req, 1);
        chk("t1_size", bus.bus_size, 2);
        chk("t1_wen", bus.bus_wen, 0);
        chk("t1_wr", bus.bus_wr, 0);
        chk("t1_addr", bus.bus_addr, 32'h1000);
        cyc();
        bus.bus_addr_ok = 0; bus.bus_data_ok = 1; bus.bus_rdata = 32'hCAFEF00D;
        smp();
        chk("t1_wreq", bus.bus_req, 0);
        chk("t1_ok", inst_ok, 1);
        chk("t1_rdata", inst_rdata, 32'hCAFEF00D);
        cyc();
        inst_req = 0;
        smp();
        chk("t1_stray_dok", inst_ok, 0);
        chk("t1_stray_req", bus.bus_req, 0);
        cyc();
        bus.bus_data_ok = 0;

        // T2: halfword store
        data_req = 1; data_wen = 4'b1100; data_addr = 32'h2002;
        data_wdata = 32'hAABB0000; bus.bus_addr_ok = 1;
        cyc();
        smp();
        chk("t2_req", bus.bus_req, 1);
        chk("t2_wr", bus.bus_wr, 1);
        chk("t2_size", bus.bus_size, 1);
        chk("t2_wen", bus.bus_wen, 4'b1100);
        chk("t2_addr", bus.bus_addr, 32'h2002);
        chk("t2_wdata", bus.bus_wdata, 32'hAABB0000);
        cyc();
        bus.bus_addr_ok = 0; bus.bus_data_ok = 1;
        smp();
        chk("t2_ok", data_ok, 1);
        chk("t2_iok", inst_ok, 0);
        cyc();
        data_req = 0; bus.bus_data_ok = 0;
        smp();
        chk("t2_after", data_ok, 0);
        cyc();

        // T3: simultaneous requests, D first
        data_req = 1; data_wen = 4'b0000; data_addr = 32'h2100;
        inst_req = 1; inst_addr = 32'h1100; bus.bus_addr_ok = 1;
        cyc();
        smp();
        chk("t3_daddr", bus.bus_addr, 32'h2100);
        chk("t3_dsize", bus.bus_size, 2);
        chk("t3_dwr", bus.bus_wr, 0);
        cyc();
        bus.bus_data_ok = 1; bus.bus_rdata = 32'h0D0D0D0D;
        smp();
        chk("t3_dok", data_ok, 1);
        chk("t3_drdata", data_rdata, 32'h0D0D0D0D);
        chk("t3_iok0", inst_ok, 0);
        cyc();
        data_req = 0; bus.bus_data_ok = 0;
        smp();
        chk("t3_gap_req", bus.bus_req, 0);
        cyc();
        smp();
        chk("t3_ireq", bus.bus_req, 1);
        chk("t3_iaddr", bus.bus_addr, 32'h1100);
        cyc();
        bus.bus_data_ok = 1; bus.bus_rdata = 32'h11111111;
        smp();
        chk("t3_iok", inst_ok, 1);
        chk("t3_dok0", data_ok, 0);
        cyc();
        inst_req = 0; bus.bus_data_ok = 0;

        // T4: flush in I_WAIT, response 2 cycles later
        inst_req = 1; inst_addr = 32'h3000;
        cyc();
        smp(); chk("t4_req", bus.bus_req, 1);
        cyc();
        flush = 1; bus.bus_addr_ok = 0;
        smp(); chk("t4_fl_ok", inst_ok, 0);
        cyc();
        flush = 0; inst_req = 0;
        smp(); chk("t4_wait_req", bus.bus_req, 0);
        cyc();
        bus.bus_data_ok = 1; bus.bus_rdata = 32'hDEAD;
        smp(); chk("t4_drop_ok", inst_ok, 0);
        cyc();
        bus.bus_data_ok = 0; inst_req = 1; inst_addr = 32'h4000;
        bus.bus_addr_ok = 1;
        smp(); chk("t4_idle_req", bus.bus_req, 0);
        cyc();
        smp(); chk("t4_new_addr", bus.bus_addr, 32'h4000);
        cyc();
        bus.bus_data_ok = 1; bus.bus_rdata = 32'h4444;
        smp();
        chk("t4_new_ok", inst_ok, 1);
        chk("t4_new_rd", inst_rdata, 32'h4444);
        cyc();
        inst_req = 0; bus.bus_data_ok = 0;

        // T4b: flush in I_ADDR, then flush together with data_ok
        inst_req = 1; inst_addr = 32'h5000;
        cyc();
        flush = 1;
        smp(); chk("t4b_addr_fl", bus.bus_req, 0);
        cyc();
        flush = 0;
        smp(); chk("t4b_back_idle", bus.bus_req, 0);
        cyc();
        smp(); chk("t4b_reissue", bus.bus_req, 1);
        cyc();
        flush = 1; bus.bus_data_ok = 1;
        smp(); chk("t4b_fl_dok", inst_ok, 0);
        cyc();
        flush = 0; bus.bus_data_ok = 0; inst_addr = 32'h5100;
        smp(); chk("t4b_idle", bus.bus_req, 0);
        cyc();
        smp(); chk("t4b_addr2", bus.bus_addr, 32'h5100);
        cyc();
        bus.bus_data_ok = 1;
        smp(); chk("t4b_ok2", inst_ok, 1);
        cyc();
        inst_req = 0; bus.bus_data_ok = 0;

        // T5: stalled address phase, then reset
        data_req = 1; data_wen = 4'b0001; data_addr = 32'h6001;
        data_wdata = 32'h55; bus.bus_addr_ok = 0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t5_hold", {bus.bus_req, bus.bus_wr, bus.bus_size,
                            bus.bus_wen, bus.bus_addr},
                {1'b1, 1'b1, 2'd0, 4'b0001, 32'h6001});
            chk("t5_wdata", bus.bus_wdata, 32'h55);
            cyc();
        end
        rst = 1;
        smp(); chk_idle("t5_inrst");
        cyc();
        rst = 0; data_req = 0;
        smp(); chk_idle("t5_post");
        cyc();

        // T6: both requesters held continuously
        exp_owner = '{1, 1, 1, 1, 1, 1};
`ifdef ARB_FAIR_EN
        exp_owner[4] = 0;
`endif
        inst_req = 1; inst_addr = 32'h7000;
        data_req = 1; data_wen = 4'b1111; data_addr = 32'h8000;
        bus.bus_addr_ok = 1; bus.bus_data_ok = 1;
        for (int c = 0; c < 18; c++) begin
            smp();
            if (bus.bus_req) owner_q.push_back(bus.bus_addr == 32'h8000);
            cyc();
        end
        grants = owner_q.size();
        chk("t6_grants", grants, 6);
        for (int k = 0; k < 6; k++)
            if (k < grants) chk($sformatf("t6_g%0d", k), owner_q[k], exp_owner[k]);
        inst_req = 0; data_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
